exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 data_in  input  8  memory read data, sampled at end of each read cycle.
REQ-004 ready  input  1  memory ready; low stalls read cycles (see Configuration).
REQ-005 dec_mode  input  3  addressing mode from decoder: 0 implied, 1 immediate, 2 zero page, 3 absolute; 4-7 treated as implied.
REQ-006 dec_store  input  1  instruction writes memory (store).
REQ-007 dec_alu_op  input  5  ALU operation code for the instruction.
REQ-008 dec_dst  input  2  destination: 0 none, 1 A, 2 X, 3 Y.
REQ-009 store_data  input  8  register value to store, from the register file.
REQ-010 addr  output  16  memory address.
REQ-011 we  output  1  memory write strobe.
REQ-012 data_out  output  8  memory write data; equals store_data while we=1, else 0x00.
REQ-013 sync  output  1  high during opcode fetch cycles.
REQ-014 ir  output  8  latched opcode.
REQ-015 pc  output  16  program counter.
REQ-016 operand  output  8  ALU second operand (immediate or memory byte).
REQ-017 alu_op  output  5  latched dec_alu_op.
REQ-018 alu_en  output  1  ALU result valid/commit strobe.
REQ-019 reg_we  output  1  register write enable; reg_sel  output  2  latched dec_dst.
REQ-020 flags_we  output  1  status register update strobe.
REQ-021 state  output  3  current state encoding, for debug.

Function
REQ-022 States and encodings SHALL be: RST_LO=0, RST_HI=1, FETCH=2, OPER_LO=3, OPER_HI=4, READ=5, WRITE=6, EXEC=7.
REQ-023 Decoder inputs are driven combinationally from data_in; they SHALL be latched with the opcode on FETCH completion only.
REQ-024 RST_LO: addr=0xFFFC; on completion pc[7:0]<=data_in; next RST_HI.
REQ-025 RST_HI: addr=0xFFFD; on completion pc[15:8]<=data_in; next FETCH.
REQ-026 FETCH: addr=pc, sync=1; ir<=data_in; pc<=pc+1; next EXEC if implied, else OPER_LO.
REQ-027 OPER_LO: addr=pc; pc<=pc+1. Immediate: operand<=data_in, next EXEC. Zero page: ea<={0x00,data_in}, next WRITE if store, else READ. Absolute: ea[7:0]<=data_in, next OPER_HI.
REQ-028 OPER_HI: addr=pc; pc<=pc+1; ea[15:8]<=data_in; next WRITE if store, else READ.
REQ-029 READ: addr=ea; operand<=data_in; next EXEC.
REQ-030 WRITE: addr=ea, we=1, data_out=store_data; next FETCH.
REQ-031 EXEC: no bus cycle; addr=pc; alu_en=1, flags_we=1, reg_we=(reg_sel!=0) for exactly one cycle; next FETCH.
REQ-032 Immediate mode with dec_store=1 SHALL execute as immediate and never assert we.
REQ-033 Cycle counts from FETCH to the next FETCH: implied 2, immediate 3, zero-page read 4, absolute read 5, zero-page store 3, absolute store 4.
REQ-034 pc increments SHALL wrap from 0xFFFF to 0x0000; ea is not incremented.
REQ-035 alu_en, reg_we, flags_we and we SHALL never be high simultaneously with sync.
REQ-036 Read cycles are RST_LO, RST_HI, FETCH, OPER_LO, OPER_HI and READ. With ready low in a read cycle, the state, pc, ir, ea, operand and all outputs SHALL hold.
REQ-037 WRITE and EXEC SHALL ignore ready and always complete in one cycle.

Reset
REQ-038 rst high SHALL immediately force state=RST_LO, pc=0x0000, ir=0x00, ea=0x0000, operand=0x00, alu_op=0, reg_sel=0. Outputs: addr=0xFFFC, we=0, sync=0, alu_en=0, reg_we=0, flags_we=0.
REQ-039 rst asserted mid-instruction, including during WRITE, SHALL abort it with no further strobes; after release the sequence restarts at RST_LO.

Configuration
REQ-040 With SEQ_READY_EN defined, ready stalls read cycles per REQ-036. With it undefined, ready SHALL be ignored, every cycle completes, and the ready port remains present.

Verification
REQ-041 Reset with mem[FFFC]=0x00, mem[FFFD]=0x80 -> first FETCH at addr 0x8000 with sync=1 on the third clock after release.
REQ-042 Immediate LDA (mode 1, dst 1), operand 0x42 at 0x8001 -> EXEC with operand=0x42, reg_we=1, reg_sel=1; next FETCH at 0x8002 after 3 cycles.
REQ-043 Absolute store (mode 3, store 1), bytes 0x34, 0x12, store_data=0xAB -> WRITE with addr=0x1234, we=1, data_out=0xAB for one cycle; next FETCH at pc+3.
REQ-044 pc=0xFFFF, implied opcode -> FETCH at 0xFFFF; next FETCH at 0x0000.
REQ-045 SEQ_READY_EN defined, ready low for 3 cycles during zero-page READ -> addr holds at ea for 4 cycles; operand is taken from the cycle where ready=1.
REQ-046 rst asserted during WRITE -> we drops to 0 immediately and addr=0xFFFC.

Source files
------------

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/operand/execute sequencer for an 8-bit core with a 16-bit bus.
// Build option: SEQ_READY_EN lets the ready input stall read cycles.
module exec_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        ready,
  input  logic [2:0]  dec_mode,
  input  logic        dec_store,
  input  logic [4:0]  dec_alu_op,
  input  logic [1:0]  dec_dst,
  input  logic [7:0]  store_data,
  output logic [15:0] addr,
  output logic        we,
  output logic [7:0]  data_out,
  output logic        sync,
  output logic [7:0]  ir,
  output logic [15:0] pc,
  output logic [7:0]  operand,
  output logic [4:0]  alu_op,
  output logic        alu_en,
  output logic        reg_we,
  output logic [1:0]  reg_sel,
  output logic        flags_we,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_RST_LO  = 3'd0,
    S_RST_HI  = 3'd1,
    S_FETCH   = 3'd2,
    S_OPER_LO = 3'd3,
    S_OPER_HI = 3'd4,
    S_READ    = 3'd5,
    S_WRITE   = 3'd6,
    S_EXEC    = 3'd7
  } state_t;

  localparam logic [1:0] M_IMP = 2'd0;
  localparam logic [1:0] M_IMM = 2'd1;
  localparam logic [1:0] M_ZP  = 2'd2;
  localparam logic [1:0] M_ABS = 2'd3;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_pc;
  logic [15:0] r_ea;
  logic [7:0]  r_ir;
  logic [7:0]  r_operand;
  logic [4:0]  r_alu_op;
  logic [1:0]  r_reg_sel;
  logic [1:0]  r_mode;
  logic        r_store;
  logic        w_go;
  logic [1:0]  w_mode;

`ifdef SEQ_READY_EN
  assign w_go = ready;
`else
  logic w_unused_ready;
  assign w_unused_ready = ready;
  assign w_go = 1'b1;
`endif

  // Modes 4-7 collapse onto implied
  assign w_mode = dec_mode[2] ? M_IMP : dec_mode[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RST_LO;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    addr     = r_pc;
    we       = 1'b0;
    sync     = 1'b0;
    alu_en   = 1'b0;
    reg_we   = 1'b0;
    flags_we = 1'b0;
    case (r_state)
      S_RST_LO: begin
        addr = 16'hFFFC;
        if (w_go) w_next = S_RST_HI;
      end
      S_RST_HI: begin
        addr = 16'hFFFD;
        if (w_go) w_next = S_FETCH;
      end
      S_FETCH: begin
        sync = 1'b1;
        if (w_go) w_next = (w_mode == M_IMP) ? S_EXEC : S_OPER_LO;
      end
      S_OPER_LO: begin
        if (w_go) begin
          case (r_mode)
            M_ZP:    w_next = r_store ? S_WRITE : S_READ;
            M_ABS:   w_next = S_OPER_HI;
            default: w_next = S_EXEC;
          endcase
        end
      end
      S_OPER_HI: begin
        if (w_go) w_next = r_store ? S_WRITE : S_READ;
      end
      S_READ: begin
        addr = r_ea;
        if (w_go) w_next = S_EXEC;
      end
      S_WRITE: begin
        addr   = r_ea;
        we     = 1'b1;
        w_next = S_FETCH;
      end
      S_EXEC: begin
        alu_en   = 1'b1;
        flags_we = 1'b1;
        reg_we   = (r_reg_sel != 2'd0);
        w_next   = S_FETCH;
      end
      default: w_next = S_RST_LO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= 16'h0000;
      r_ea      <= 16'h0000;
      r_ir      <= 8'h00;
      r_operand <= 8'h00;
      r_alu_op  <= 5'd0;
      r_reg_sel <= 2'd0;
      r_mode    <= M_IMP;
      r_store   <= 1'b0;
    end else if (w_go) begin
      case (r_state)
        S_RST_LO: r_pc[7:0]  <= data_in;
        S_RST_HI: r_pc[15:8] <= data_in;
        S_FETCH: begin
          r_ir      <= data_in;
          r_pc      <= r_pc + 16'd1;
          r_mode    <= w_mode;
          r_store   <= dec_store;
          r_alu_op  <= dec_alu_op;
          r_reg_sel <= dec_dst;
        end
        S_OPER_LO: begin
          r_pc <= r_pc + 16'd1;
          case (r_mode)
            M_IMM:   r_operand <= data_in;
            M_ZP:    r_ea <= {8'h00, data_in};
            M_ABS:   r_ea[7:0] <= data_in;
            default: ;
          endcase
        end
        S_OPER_HI: begin
          r_pc       <= r_pc + 16'd1;
          r_ea[15:8] <= data_in;
        end
        S_READ:  r_operand <= data_in;
        default: ;
      endcase
    end
  end

  assign data_out = we ? store_data : 8'h00;
  assign ir       = r_ir;
  assign pc       = r_pc;
  assign operand  = r_operand;
  assign alu_op   = r_alu_op;
  assign reg_sel  = r_reg_sel;
  assign state    = r_state;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: flat memory model and a bit-field decoder.
// Opcode fields: [2:0] mode, [3] store, [5:4] dst; alu_op = {op[7:6], op[2:0]}.
module tb_exec_sequencer;
  logic        clk;
  logic        rst;
  logic [7:0]  data_in;
  logic        ready;
  logic [2:0]  dec_mode;
  logic        dec_store;
  logic [4:0]  dec_alu_op;
  logic [1:0]  dec_dst;
  logic [7:0]  store_data;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  data_out;
  logic        sync;
  logic [7:0]  ir;
  logic [15:0] pc;
  logic [7:0]  operand;
  logic [4:0]  alu_op;
  logic        alu_en;
  logic        reg_we;
  logic [1:0]  reg_sel;
  logic        flags_we;
  logic [2:0]  state;

  logic [7:0] mem [0:65535];
  int total;
  int bad;

  exec_sequencer dut (
    .clk(clk), .rst(rst), .data_in(data_in), .ready(ready),
    .dec_mode(dec_mode), .dec_store(dec_store),
    .dec_alu_op(dec_alu_op), .dec_dst(dec_dst),
    .store_data(store_data), .addr(addr), .we(we),
    .data_out(data_out), .sync(sync), .ir(ir), .pc(pc),
    .operand(operand), .alu_op(alu_op), .alu_en(alu_en),
    .reg_we(reg_we), .reg_sel(reg_sel), .flags_we(flags_we),
    .state(state)
  );

  assign data_in    = mem[addr];
  assign dec_mode   = data_in[2:0];
  assign dec_store  = data_in[3];
  assign dec_dst    = data_in[5:4];
  assign dec_alu_op = {data_in[7:6], data_in[2:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobes must never coincide with an opcode fetch
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      total++;
      assert (!(sync && (alu_en || reg_we || flags_we || we))) else begin
        bad++;
        $error("FAIL sync_excl observed=%0b%0b%0b%0b%0b expected=no overlap",
               sync, alu_en, reg_we, flags_we, we);
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    ready = 1'b1;
    store_data = 8'hAB;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'h11; mem[16'h8001] = 8'h42;
    mem[16'h8002] = 8'h0B; mem[16'h8003] = 8'h34; mem[16'h8004] = 8'h12;
    mem[16'h8005] = 8'h00;
    mem[16'h8006] = 8'h22; mem[16'h8007] = 8'h50;
    mem[16'h8008] = 8'h19; mem[16'h8009] = 8'h99;
    mem[16'h800A] = 8'h33; mem[16'h800B] = 8'h78; mem[16'h800C] = 8'h56;
    mem[16'h800D] = 8'h0A; mem[16'h800E] = 8'h60;
    mem[16'h0050] = 8'h77;
    mem[16'h5678] = 8'h5A;

    #1 rst = 1'b1;
    #2;
    chk("rst_state", state, 0);
    chk("rst_addr", addr, 16'hFFFC);
    chk("rst_we", we, 0);
    chk("rst_sync", sync, 0);
    chk("rst_strobes", {alu_en, reg_we, flags_we}, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_operand", operand, 0);
    chk("rst_regsel_aluop", {reg_sel, alu_op}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    tick();
    chk("rsthi_state", state, 1);
    chk("rsthi_addr", addr, 16'hFFFD);
    tick();
    chk("f0_state", state, 2);
    chk("f0_addr", addr, 16'h8000);
    chk("f0_sync", sync, 1);

    tick();
    chk("imm_operlo_addr", addr, 16'h8001);
    chk("imm_ir", ir, 8'h11);
    tick();
    chk("imm_exec_state", state, 7);
    chk("imm_operand", operand, 8'h42);
    chk("imm_reg_we", reg_we, 1);
    chk("imm_reg_sel", reg_sel, 1);
    chk("imm_alu_en_flags", {alu_en, flags_we}, 2'b11);
    chk("imm_alu_op", alu_op, 5'd1);
    chk("imm_exec_addr", addr, 16'h8002);
    tick();
    chk("f1_addr", addr, 16'h8002);
    chk("f1_sync", sync, 1);
    chk("f1_alu_en", alu_en, 0);

    tick();
    chk("abss_operlo", {state, addr}, {3'd3, 16'h8003});
    tick();
    chk("abss_operhi", {state, addr}, {3'd4, 16'h8004});
    tick();
    chk("abss_write_state", state, 6);
    chk("abss_write_addr", addr, 16'h1234);
    chk("abss_we", we, 1);
    chk("abss_data_out", data_out, 8'hAB);
    chk("abss_sync", sync, 0);
    tick();
    chk("f2_addr", addr, 16'h8005);
    chk("f2_we_dout", {we, data_out}, 9'h000);

    tick();
    chk("imp_exec_state", state, 7);
    chk("imp_reg_we", reg_we, 0);
    chk("imp_alu_en", alu_en, 1);
    tick();
    chk("f3_addr", {state, addr}, {3'd2, 16'h8006});

    tick();
    chk("zp_operlo", addr, 16'h8007);
    tick();
    chk("zp_read_state", state, 5);
    chk("zp_read_addr", addr, 16'h0050);
`ifdef SEQ_READY_EN
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_state", state, 5);
      chk("stall_addr", addr, 16'h0050);
      chk("stall_operand", operand, 8'h42);
      chk("stall_pc", pc, 16'h8008);
    end
    ready = 1'b1;
    tick();
`else
    ready = 1'b0;
    tick();
    ready = 1'b1;
`endif
    chk("zp_exec_state", state, 7);
    chk("zp_operand", operand, 8'h77);
    chk("zp_reg_sel", reg_sel, 2);
    chk("zp_reg_we", reg_we, 1);
    chk("zp_alu_op", alu_op, 5'd2);
    tick();
    chk("f4_addr", {state, addr}, {3'd2, 16'h8008});

    tick();
    chk("immst_operlo_we", {state, we}, {3'd3, 1'b0});
    tick();
    chk("immst_exec_state", state, 7);
    chk("immst_we", we, 0);
    chk("immst_operand", operand, 8'h99);
    tick();
    chk("f5_addr", {state, addr}, {3'd2, 16'h800A});

    tick();
    tick();
    chk("absr_operhi", {state, addr}, {3'd4, 16'h800C});
    tick();
    chk("absr_read_addr", {state, addr}, {3'd5, 16'h5678});
    tick();
    chk("absr_operand", operand, 8'h5A);
    chk("absr_reg_sel", reg_sel, 3);
    tick();
    chk("f6_addr", {state, addr}, {3'd2, 16'h800D});

    store_data = 8'h3C;
    tick();
    tick();
    chk("zps_write_addr", {state, addr}, {3'd6, 16'h0060});
    chk("zps_data_out", {we, data_out}, {1'b1, 8'h3C});
    #2 rst = 1'b1;
    #1;
    chk("abort_we", we, 0);
    chk("abort_addr", addr, 16'hFFFC);
    chk("abort_state", state, 0);
    chk("abort_pc", pc, 0);

    mem[16'hFFFC] = 8'hFF;
    mem[16'hFFFD] = 8'hFF;
    mem[16'hFFFF] = 8'h00;
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    tick();
    chk("wrap_fetch", {state, addr}, {3'd2, 16'hFFFF});
    chk("wrap_sync", sync, 1);
    tick();
    chk("wrap_exec_pc", pc, 16'h0000);
    tick();
    chk("wrap_next_fetch", {state, addr}, {3'd2, 16'h0000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
